// File: rtl/kyber_pkg.sv
// Shared constants and helpers for the Kyber coefficient datapath (q = 3329).
// Barrett parameters: k = 24, m = floor(2^24 / q).
package kyber_pkg;

  localparam int unsigned KYBER_Q   = 32'd3329;
  localparam int unsigned COEF_W    = 32'd12;
  localparam int unsigned BARRETT_K = 32'd24;
  localparam int unsigned BARRETT_M = 32'd5039;
  localparam int unsigned PROD_W    = 32'd24;
  localparam int unsigned QUOT_W    = 32'd13;
  localparam int unsigned RED_W     = 32'd13;
  localparam int unsigned PM_W      = PROD_W + QUOT_W;

  typedef logic [COEF_W-1:0] coef_t;
  typedef logic [PROD_W-1:0] prod_t;
  typedef logic [QUOT_W-1:0] quot_t;
  typedef logic [RED_W-1:0]  red_t;

  // Quotient estimate t = (P * m) >> k, evaluated at the full 37-bit product width.
  function automatic quot_t barrett_quot(input prod_t p);
    logic [PM_W-1:0] pm;
    pm = PM_W'(p) * PM_W'(BARRETT_M);
    return QUOT_W'(pm >> BARRETT_K);
  endfunction

endpackage

// File: rtl/csub_q.sv
// Conditional subtract of q: maps a Barrett remainder r in [0, 2q) to [0, q).
module csub_q
  import kyber_pkg::*;
(
  input  logic [RED_W-1:0]  r,
  output logic [COEF_W-1:0] y
);

  localparam logic [RED_W-1:0] Q_R = RED_W'(KYBER_Q);

  // Select r - q when r is at or above q, otherwise pass r through.
  always_comb begin
    y = '0;
    if (r >= Q_R) begin
      y = COEF_W'(r - Q_R);
    end else begin
      y = COEF_W'(r);
    end
  end

endmodule

// File: rtl/modmul_barrett.sv
// Three-stage pipelined A*B mod 3329 using Barrett reduction, with ready/valid
// handshake, per-stage valid bits and a passthrough tag.
module modmul_barrett
  import kyber_pkg::*;
#(
  parameter int unsigned TAG_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [COEF_W-1:0] in_a,
  input  logic [COEF_W-1:0] in_b,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [COEF_W-1:0] out_data,
  output logic [TAG_W-1:0]  out_tag
);

  logic             v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
  prod_t            p1_q, p1_d, p2_q, p2_d;
  quot_t            t2_q, t2_d;
  logic [TAG_W-1:0] tag1_q, tag1_d, tag2_q, tag2_d, tag3_q, tag3_d;
  coef_t            data3_q, data3_d;

  logic  load1_s, load2_s, load3_s;
  prod_t p_s, tq_s;
  red_t  r_s;
  coef_t red_s;

  // Stall chain: a stage loads when it is empty or its consumer is loading.
  always_comb begin
    load3_s  = !v3_q || out_ready;
    load2_s  = !v2_q || load3_s;
    load1_s  = !v1_q || load2_s;
    in_ready = load1_s;
  end

  // Datapath arithmetic; t*q < 2^24 and r is known to fit 13 bits.
  always_comb begin
    p_s  = PROD_W'(in_a) * PROD_W'(in_b);
    tq_s = PROD_W'(t2_q) * PROD_W'(KYBER_Q);
    r_s  = RED_W'(p2_q - tq_s);
  end

  csub_q u_csub_q (
    .r (r_s),
    .y (red_s)
  );

  // Next-state for all three stages; payload only moves when the upstream is valid.
  always_comb begin
    v1_d    = v1_q;
    p1_d    = p1_q;
    tag1_d  = tag1_q;
    v2_d    = v2_q;
    p2_d    = p2_q;
    t2_d    = t2_q;
    tag2_d  = tag2_q;
    v3_d    = v3_q;
    data3_d = data3_q;
    tag3_d  = tag3_q;

    if (load1_s) begin
      v1_d = in_valid;
      if (in_valid) begin
        p1_d   = p_s;
        tag1_d = in_tag;
      end else begin
        p1_d   = p1_q;
        tag1_d = tag1_q;
      end
    end else begin
      v1_d = v1_q;
    end

    if (load2_s) begin
      v2_d = v1_q;
      if (v1_q) begin
        p2_d   = p1_q;
        t2_d   = barrett_quot(p1_q);
        tag2_d = tag1_q;
      end else begin
        p2_d   = p2_q;
        t2_d   = t2_q;
        tag2_d = tag2_q;
      end
    end else begin
      v2_d = v2_q;
    end

    if (load3_s) begin
      v3_d = v2_q;
      if (v2_q) begin
        data3_d = red_s;
        tag3_d  = tag2_q;
      end else begin
        data3_d = data3_q;
        tag3_d  = tag3_q;
      end
    end else begin
      v3_d = v3_q;
    end
  end

  // Pipeline registers with synchronous reset that discards in-flight items.
  always_ff @(posedge clk) begin
    if (reset) begin
      v1_q    <= 1'b0;
      p1_q    <= '0;
      tag1_q  <= '0;
      v2_q    <= 1'b0;
      p2_q    <= '0;
      t2_q    <= '0;
      tag2_q  <= '0;
      v3_q    <= 1'b0;
      data3_q <= '0;
      tag3_q  <= '0;
    end else begin
      v1_q    <= v1_d;
      p1_q    <= p1_d;
      tag1_q  <= tag1_d;
      v2_q    <= v2_d;
      p2_q    <= p2_d;
      t2_q    <= t2_d;
      tag2_q  <= tag2_d;
      v3_q    <= v3_d;
      data3_q <= data3_d;
      tag3_q  <= tag3_d;
    end
  end

  assign out_valid = v3_q;
  assign out_data  = data3_q;
  assign out_tag   = tag3_q;

endmodule

// File: tb/tb_modmul_barrett.sv
// Self-checking bench for modmul_barrett: scoreboard of (A*B) % 3329 in input order,
// checked on every output cycle, plus directed vectors with hand-computed results.
module tb_modmul_barrett;

  localparam int TAG_W = 8;
  localparam int Q     = 3329;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [11:0]      in_a = 12'd0;
  logic [11:0]      in_b = 12'd0;
  logic [TAG_W-1:0] in_tag = 8'd0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [11:0]      out_data;
  logic [TAG_W-1:0] out_tag;

  int n_checks = 0;
  int n_fail   = 0;
  int accepted = 0;
  int received = 0;
  int exp_data_q[$];
  int exp_tag_q[$];
  bit prev_hold = 1'b0;
  int prev_data = 0;
  int prev_tag  = 0;

  modmul_barrett #(.TAG_W(TAG_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_tag   (out_tag)
  );

  always #5 clk = ~clk;

  function automatic int model(input int a, input int b);
    return (a * b) % Q;
  endfunction

  task automatic chk(input string nm, input longint act, input longint req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: actual=%0d required=%0d", nm, act, req);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: inputs are stable between negedge and the next posedge, so the
  // handshakes observed here are exactly the transfers of the coming edge.
  always @(negedge clk) begin
    if (reset) begin
      accepted  = accepted - exp_data_q.size();
      exp_data_q.delete();
      exp_tag_q.delete();
      prev_hold = 1'b0;
    end else begin
      if (dut.v2_q) chk("r_lt_2q", longint'(dut.r_s < 13'd6658), 1);
      if (out_valid) begin
        if (exp_data_q.size() == 0) begin
          chk("stale_output", 1, 0);
        end else begin
          chk("out_data", out_data, exp_data_q[0]);
          chk("out_tag", out_tag, exp_tag_q[0]);
          if (out_ready) begin
            void'(exp_data_q.pop_front());
            void'(exp_tag_q.pop_front());
            received++;
          end
        end
        if (prev_hold) begin
          chk("hold_data", out_data, prev_data);
          chk("hold_tag", out_tag, prev_tag);
        end
      end
      prev_hold = out_valid && !out_ready;
      prev_data = out_data;
      prev_tag  = out_tag;
      if (in_valid && in_ready) begin
        exp_data_q.push_back(model(in_a, in_b));
        exp_tag_q.push_back(in_tag);
        accepted++;
      end
    end
  end

  task automatic drain();
    out_ready = 1'b1;
    in_valid  = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (exp_data_q.size() == 0 && !out_valid) break;
      cyc();
    end
    chk("drain_empty", exp_data_q.size(), 0);
    chk("drain_out_valid", out_valid, 0);
  endtask

  // One item into an empty pipe; verifies exact 3-cycle latency and a literal result.
  task automatic directed(input int a, input int b, input int tag, input int req, input string nm);
    chk({nm, "_model"}, model(a, b), req);
    in_a = 12'(a); in_b = 12'(b); in_tag = 8'(tag);
    in_valid = 1'b1; out_ready = 1'b1;
    chk({nm, "_in_ready"}, in_ready, 1);
    cyc();
    in_valid = 1'b0;
    cyc();
    chk({nm, "_early_valid"}, out_valid, 0);
    cyc();
    chk({nm, "_valid"}, out_valid, 1);
    chk({nm, "_data"}, out_data, req);
    chk({nm, "_tag"}, out_tag, tag);
    cyc();
  endtask

  int bp_a[5] = '{100, 3328, 4095, 7, 1234};
  int bp_b[5] = '{200, 3328, 4095, 3329, 2};
  int base;
  int idx;
  int sent;
  bit take;

  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_tag", out_tag, 0);
    chk("rst_in_ready", in_ready, 1);

    directed(3328, 3328, 8'hA5, 1, "wrap");
    directed(0, 1234, 8'h01, 0, "zero");
    directed(1, 3328, 8'h02, 3328, "one");
    directed(2, 1665, 8'h03, 1, "half");
    directed(4095, 4095, 8'h04, 852, "max");
    directed(3329, 7, 8'h05, 0, "q_times");

    base = received;
    out_ready = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      in_a = 12'($urandom); in_b = 12'($urandom); in_tag = 8'($urandom);
      in_valid = 1'b1;
      @(negedge clk);
      if (!in_ready) chk("stream_in_ready", in_ready, 1);
      cyc();
    end
    drain();
    chk("stream_count", received - base, 1000);

    base = received;
    out_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 8; c++) begin
      in_a = 12'(bp_a[idx]); in_b = 12'(bp_b[idx]); in_tag = 8'(8'h40 + idx);
      in_valid = 1'b1;
      @(negedge clk);
      take = in_ready;
      cyc();
      if (take) idx++;
    end
    chk("bp_accepted", idx, 3);
    chk("bp_in_ready_low", in_ready, 0);
    out_ready = 1'b1;
    for (int c = 0; c < 20 && idx < 5; c++) begin
      in_a = 12'(bp_a[idx]); in_b = 12'(bp_b[idx]); in_tag = 8'(8'h40 + idx);
      in_valid = 1'b1;
      @(negedge clk);
      take = in_ready;
      cyc();
      if (take) idx++;
    end
    chk("bp_all_sent", idx, 5);
    drain();
    chk("bp_count", received - base, 5);

    base = received;
    sent = 0;
    for (int c = 0; c < 60000 && sent < 10000; c++) begin
      in_a = 12'($urandom); in_b = 12'($urandom); in_tag = 8'($urandom);
      in_valid  = ($urandom_range(3) != 0);
      out_ready = $urandom_range(1) != 0;
      @(negedge clk);
      take = in_valid && in_ready;
      cyc();
      if (take) sent++;
    end
    chk("rand_sent", sent, 10000);
    drain();
    chk("rand_count", received - base, 10000);

    out_ready = 1'b1;
    in_a = 12'd100; in_b = 12'd200; in_tag = 8'h11; in_valid = 1'b1;
    cyc();
    in_a = 12'd300; in_b = 12'd400; in_tag = 8'h22;
    cyc();
    in_valid = 1'b0;
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    chk("midrst_out_valid", out_valid, 0);
    for (int c = 0; c < 6; c++) begin
      cyc();
      chk("midrst_no_stale", out_valid, 0);
    end
    directed(3328, 3328, 8'h77, 1, "post_rst");

    drain();
    chk("total_in_out", received, accepted);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
